// File: rtl/norm_road_sequencer_pkg.sv
// Shared definitions for the normal-operation road sequencer and its allow decoder.
package norm_road_sequencer_pkg;

    localparam int NUM_ROADS = 4;

    typedef logic [1:0] road_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GREEN = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/norm_road_sequencer_rr_next_road.sv
// Round-robin next-road picker: first requester after the current road, current road last.
module rr_next_road
    import norm_road_sequencer_pkg::*;
(
    input  road_t                cur_road,
    input  logic [NUM_ROADS-1:0] req,
    output road_t                next_road
);

    // Walk from lowest to highest priority so the nearest requester overwrites the rest;
    // with no requester at all the plain rotation default survives.
    always_comb begin
        next_road = cur_road + road_t'(1);
        for (int k = NUM_ROADS; k >= 1; k--) begin
            if (req[cur_road + road_t'(k)]) begin
                next_road = cur_road + road_t'(k);
            end
        end
    end

endmodule

// File: rtl/norm_road_sequencer.sv
// Normal-mode phase sequencer: fixed green per road, all-red clearance, round-robin skip of idle roads.
module norm_road_sequencer
    import norm_road_sequencer_pkg::*;
#(
    parameter int GREEN_CYCLES = 10,
    parameter int CLEAR_CYCLES = 3,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 norm_mode,
    input  logic [NUM_ROADS-1:0] road_req,
    output logic [1:0]           current_road_norm,
    output logic                 norm_op_en,
    output logic                 road_change
);

    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    road_t            road_nx, rr_road;
    logic             en_nx, chg_nx;

    rr_next_road u_rr_next_road (
        .cur_road  (current_road_norm),
        .req       (road_req),
        .next_road (rr_road)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            current_road_norm <= '0;
            norm_op_en        <= 1'b0;
            road_change       <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            current_road_norm <= road_nx;
            norm_op_en        <= en_nx;
            road_change       <= chg_nx;
        end
    end

    // Outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        road_nx  = current_road_norm;
        en_nx    = 1'b0;
        chg_nx   = 1'b0;
        if (!norm_mode) begin
            // Abort: the interrupted green is dropped, the road is kept for re-entry.
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = GREEN;
                    cnt_nx   = '0;
                    en_nx    = 1'b1;
                end
                GREEN: begin
                    if (cnt == GREEN_LAST) begin
                        state_nx = CLEAR;
                        cnt_nx   = '0;
                    end else begin
                        en_nx = 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        state_nx = GREEN;
                        cnt_nx   = '0;
                        road_nx  = rr_road;
                        en_nx    = 1'b1;
                        chg_nx   = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_road_sequencer.sv
// Bench for norm_road_sequencer: default and 1/1-cycle instances against a period-based model.
module tb_norm_road_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       norm_mode = 1'b0;
    logic [3:0] road_req = 4'b0000;
    logic [1:0] road0, road1;
    logic       en0, en1, chg0, chg1;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    norm_road_sequencer #(.GREEN_CYCLES(10), .CLEAR_CYCLES(3), .CNT_W(8)) u_dut_def (
        .clk(clk), .rst(rst), .norm_mode(norm_mode), .road_req(road_req),
        .current_road_norm(road0), .norm_op_en(en0), .road_change(chg0)
    );

    norm_road_sequencer #(.GREEN_CYCLES(1), .CLEAR_CYCLES(1), .CNT_W(4)) u_dut_min (
        .clk(clk), .rst(rst), .norm_mode(norm_mode), .road_req(road_req),
        .current_road_norm(road1), .norm_op_en(en1), .road_change(chg1)
    );

    // Model: each service is one period of G+C cycles; green is the first G cycles of it.
    function automatic int g_of(int i);
        return (i == 0) ? 10 : 1;
    endfunction

    function automatic int c_of(int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic int pick_next(int cur, logic [3:0] req);
        for (int d = 1; d <= 4; d++) begin
            if (req[(cur + d) % 4]) return (cur + d) % 4;
        end
        return (cur + 1) % 4;
    endfunction

    bit m_act[2];
    int m_pos[2];
    int m_road[2];
    bit m_chg[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0; m_pos[i] <= 0; m_road[i] <= 0; m_chg[i] <= 1'b0;
            end else if (!norm_mode) begin
                m_act[i] <= 1'b0; m_pos[i] <= 0; m_chg[i] <= 1'b0;
            end else if (!m_act[i]) begin
                m_act[i] <= 1'b1; m_pos[i] <= 0; m_chg[i] <= 1'b0;
            end else if (m_pos[i] == g_of(i) + c_of(i) - 1) begin
                m_road[i] <= pick_next(m_road[i], road_req);
                m_pos[i]  <= 0;
                m_chg[i]  <= 1'b1;
            end else begin
                m_pos[i] <= m_pos[i] + 1;
                m_chg[i] <= 1'b0;
            end
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("def_road", int'(road0), m_road[0]);
            cmp("def_en",   int'(en0),   int'(m_act[0] && m_pos[0] < g_of(0)));
            cmp("def_chg",  int'(chg0),  int'(m_chg[0]));
            cmp("min_road", int'(road1), m_road[1]);
            cmp("min_en",   int'(en1),   int'(m_act[1] && m_pos[1] < g_of(1)));
            cmp("min_chg",  int'(chg1),  int'(m_chg[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_chg(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!chg0 && k < 60);
        if (!chg0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no road_change within %0d cycles", nm, k);
        end
    endtask

    int green_cnt;

    initial begin
        cyc(2);
        check_en = 1'b1;
        cmp("reset_road", int'(road0), 0);
        cmp("reset_en",   int'(en0),   0);
        cmp("reset_chg",  int'(chg0),  0);

        // Basic cycle, plus the 1/1 instance alternating.
        rst = 1'b0; norm_mode = 1'b1; road_req = 4'b1111;
        cyc(1);
        cmp("basic_first_en", int'(en0), 1);
        cmp("min_s1_en", int'(en1), 1);
        cyc(1);
        cmp("min_s2_en", int'(en1), 0);
        cyc(1);
        cmp("min_s3_road", int'(road1), 1);
        cmp("min_s3_chg",  int'(chg1), 1);
        cyc(7);
        cmp("basic_s10_en", int'(en0), 1);
        cyc(1);
        cmp("basic_s11_en", int'(en0), 0);
        cyc(3);
        cmp("basic_s14_road", int'(road0), 1);
        cmp("basic_s14_chg",  int'(chg0), 1);
        cmp("basic_s14_en",   int'(en0), 1);
        wait_chg("basic_to2");
        cmp("basic_road2", int'(road0), 2);
        wait_chg("basic_to3");
        cmp("basic_road3", int'(road0), 3);
        wait_chg("basic_to0");
        cmp("basic_road0", int'(road0), 0);

        // Skip: only road 3 requests.
        road_req = 4'b1000;
        wait_chg("skip_first");
        cmp("skip_road3", int'(road0), 3);
        wait_chg("skip_regrant");
        cmp("skip_regrant_road3", int'(road0), 3);

        // Wrap and empty-request rotation.
        road_req = 4'b0001;
        wait_chg("wrap");
        cmp("wrap_road0", int'(road0), 0);
        road_req = 4'b0100;
        wait_chg("to_road2");
        cmp("to_road2", int'(road0), 2);
        road_req = 4'b0000;
        wait_chg("rotate");
        cmp("rotate_road3", int'(road0), 3);

        // Abort at green cnt=5 on road 2, then a full green on re-enable.
        road_req = 4'b0100;
        wait_chg("abort_setup");
        cmp("abort_setup_road", int'(road0), 2);
        cyc(5);
        norm_mode = 1'b0;
        cyc(1);
        cmp("abort_en",   int'(en0), 0);
        cmp("abort_road", int'(road0), 2);
        cmp("abort_chg",  int'(chg0), 0);
        cyc(2);
        norm_mode = 1'b1;
        green_cnt = 0;
        for (int s = 0; s < 13; s++) begin
            cyc(1);
            if (en0) green_cnt++;
        end
        cmp("abort_full_green", green_cnt, 10);
        cmp("abort_resume_road", int'(road0), 2);

        // Reset during CLEAR cnt=1 on road 1.
        road_req = 4'b0010;
        wait_chg("rst_setup");
        cmp("rst_setup_road", int'(road0), 1);
        cyc(11);
        rst = 1'b1;
        cyc(1);
        cmp("midrst_road", int'(road0), 0);
        cmp("midrst_en",   int'(en0), 0);
        cmp("midrst_chg",  int'(chg0), 0);
        rst = 1'b0;

        // Randomized traffic, mode drops and occasional resets.
        for (int s = 0; s < 1500; s++) begin
            road_req  = 4'($urandom_range(0, 15));
            norm_mode = ($urandom_range(0, 39) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/norm_road_sequencer.md
Name: norm_road_sequencer

Overview:
Normal-operation phase sequencer that sits directly upstream of the normal-operation allow decoder. It drives `current_road_norm` and `norm_op_en` into that decoder. It grants each road a fixed green window, follows it with an all-red clearance interval, then selects the next road in round-robin order, skipping roads with no vehicle request. It is enabled by the top-level mode controller whenever the intersection is in normal mode.

Parameters:
- GREEN_CYCLES, 10, green window per road in clk cycles; must be ≥1.
- CLEAR_CYCLES, 3, all-red clearance between greens in clk cycles; must be ≥1.
- CNT_W, 8, phase counter width; must satisfy 2^CNT_W > max(GREEN_CYCLES, CLEAR_CYCLES).

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- norm_mode, input, 1, normal-operation mode enable from the mode controller.
- road_req, input, 4, per-road vehicle-present flags; bit i = road i.
- current_road_norm, output, 2, road currently owning the intersection.
- norm_op_en, output, 1, high only while the current road holds green.
- road_change, output, 1, one-cycle pulse on the first cycle a new `current_road_norm` value is visible.

Behaviour:
- All outputs and state are registered.
- Reset values (rst=1 at an edge):
  - state=IDLE, cnt=0.
  - current_road_norm=0, norm_op_en=0, road_change=0.
  - rst overrides every other input.
- States: IDLE, GREEN, CLEAR.
- IDLE:
  - norm_op_en=0.
  - At an edge with norm_op_en… with norm_mode=1: go to GREEN and clear cnt; current_road_norm is unchanged (it is the last road held).
- GREEN:
  - norm_op_en=1 on every cycle spent in GREEN.
  - cnt increments each cycle.
  - At an edge with cnt==GREEN_CYCLES-1: go to CLEAR and clear cnt.
  - Result: green lasts exactly GREEN_CYCLES cycles.
- CLEAR:
  - norm_op_en=0; current_road_norm is held.
  - cnt increments each cycle.
  - At an edge with cnt==CLEAR_CYCLES-1:
    - Load current_road_norm with the next road, go to GREEN, clear cnt.
    - road_change=1 for exactly that following cycle; 0 otherwise.
- Next-road selection:
  - Combinational, evaluated from road_req at the final CLEAR edge.
  - Search order: cur+1, cur+2, cur+3, cur, all mod 4 (wrap 3→0). The first road with road_req set wins.
  - If road_req==0, the next road is cur+1 mod 4 (plain rotation).
  - The current road is re-granted only when it is the sole requester.
- norm_mode=0 at any edge (rst=0):
  - Next state IDLE, norm_op_en=0, cnt cleared.
  - current_road_norm held; no road_change pulse.
  - This is an abort: a partially served green is not resumed. Re-enable starts a full GREEN on the held road.
- Mid-operation reset: returns to reset values on the next edge, regardless of state or cnt.
- norm_op_en and road_change are never high in IDLE.
- current_road_norm changes only on the CLEAR→GREEN edge or on reset.
- Counter arithmetic is unsigned CNT_W bits and never wraps under legal parameters.

Decomposition:
- Shared package contents:
  - State encoding constants: IDLE=2'd0, GREEN=2'd1, CLEAR=2'd2.
  - NUM_ROADS=4.
  - Road-index type (2-bit).
  - Both the decoder and this block use the package.
- One natural sub-module, `rr_next_road`: purely combinational. Inputs are the 2-bit current road and 4-bit req; output is the 2-bit next road per the search order above. Instantiated once.

Test Plan:
1. Basic cycle:
   - Stimulus: rst for 2 cycles, then norm_mode=1, road_req=4'b1111, defaults.
   - Response: road 0 with norm_op_en=1 for exactly 10 cycles, then 0 for 3 cycles. current_road_norm=1 with road_change=1 for one cycle, then norm_op_en=1 again. Sequence continues 0→1→2→3→0.
2. Skip:
   - Stimulus: on road 0, road_req=4'b1000.
   - Response: after clearance the next road is 3. With req still 4'b1000, road 3 is re-granted after its own clearance, and road_change pulses each time.
3. Wrap:
   - Stimulus: current road 3, road_req=4'b0001.
   - Response: next road is 0. With road_req=4'b0000 from road 2, next road is 3.
4. Abort:
   - Stimulus: drop norm_mode when GREEN cnt=5 on road 2.
   - Response: norm_op_en=0 the next cycle, road held at 2, no road_change pulse. Re-assert norm_mode: road 2 gets a full 10-cycle green.
5. Reset mid-CLEAR:
   - Stimulus: assert rst for 1 cycle during CLEAR cnt=1 on road 1.
   - Response: next cycle current_road_norm=0, norm_op_en=0, road_change=0, IDLE.
6. Parameter corner:
   - Stimulus: GREEN_CYCLES=1, CLEAR_CYCLES=1.
   - Response: norm_op_en alternates 1/0 each cycle, and the road advances every 2 cycles.
